// File: rtl/microwave_timer_pkg.sv
// ----------------------------------------------------------------------------
// microwave_timer_pkg
//   Shared types and constants for the microwave cook timer.
//   - bcd_t        : one 4-bit BCD digit
//   - DIGIT_MAX    : highest sec_ones / mins digit (wrap value on borrow)
//   - SEC_TENS_MAX : highest sec_tens digit (wrap value on borrow)
//   - cmd_e        : per-cycle command decoded from clearn/loadn/enable/zero
//   - is_valid_digit() : keypad digit range check (0..9)
// ----------------------------------------------------------------------------
package microwave_timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX    = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_COUNT = 2'd2,
    CMD_HOLD  = 2'd3
  } cmd_e;

  function automatic logic is_valid_digit(input bcd_t d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// ----------------------------------------------------------------------------
// microwave_timer_if
//   Keypad/control inputs and display outputs of the cook timer.
//   Signals:
//     loadn    : active-low load strobe for one keypad digit
//     enable   : 1 = count down, 0 = hold
//     data     : BCD keypad digit
//     sec_ones : BCD seconds units
//     sec_tens : BCD seconds tens
//     mins     : BCD minutes
//     zero     : all three digits are 0
//   Modports:
//     master : keypad / magnetron-control side (drives loadn, enable, data)
//     slave  : timer side (drives the digits and zero)
// ----------------------------------------------------------------------------
interface microwave_timer_if
  import microwave_timer_pkg::*;
  ;

  logic loadn;
  logic enable;
  bcd_t data;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t mins;
  logic zero;

  modport master (
    output loadn, enable, data,
    input  sec_ones, sec_tens, mins, zero
  );

  modport slave (
    input  loadn, enable, data,
    output sec_ones, sec_tens, mins, zero
  );

endinterface

// File: rtl/microwave_timer_bcd_down_digit.sv
// ----------------------------------------------------------------------------
// microwave_timer_bcd_down_digit
//   One BCD down-counting digit with parallel load.
//   Parameters:
//     WRAP_MAX : value taken when decrementing from 0
//   Ports:
//     clk        in  clock, rising edge
//     rst_n      in  asynchronous active-low clear (digit -> 0)
//     load_i     in  load load_val_i this edge (wins over dec_i)
//     load_val_i in  value to load
//     dec_i      in  decrement this edge
//     q_o        out current digit (registered)
//     borrow_o   out decrementing from 0 this edge; feeds the next digit's dec_i
// ----------------------------------------------------------------------------
module microwave_timer_bcd_down_digit
  import microwave_timer_pkg::*;
#(
  parameter bcd_t WRAP_MAX = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic dec_i,
  output bcd_t q_o,
  output logic borrow_o
);

  bcd_t q_q;
  bcd_t q_d;

  // A digit above WRAP_MAX (possible after a shift-in) just decrements
  // normally, so out-of-range values walk back into range by themselves.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (dec_i) begin
      q_d = (q_q == 4'd0) ? WRAP_MAX : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o      = q_q;
  assign borrow_o = dec_i && !load_i && (q_q == 4'd0);

endmodule

// File: rtl/microwave_timer.sv
// ----------------------------------------------------------------------------
// microwave_timer
//   Microwave-oven cook timer. Keypad digits shift into a 3-digit BCD M:SS
//   value; while enable=1 the value counts down one step per clock (1 Hz)
//   and stops at 0:00, where zero is raised.
//   Parameters:
//     SEC_TENS_MAX : highest sec_tens digit (wrap value on borrow)
//     DIGIT_MAX    : highest sec_ones / mins digit (wrap value on borrow)
//   Ports:
//     clock  in  system clock, rising edge, 1 Hz nominal
//     clearn in  asynchronous active-low clear, forces 0:00
//     tmr_if     slave modport: loadn, enable, data in; sec_ones, sec_tens,
//                mins, zero out (zero is combinational from the digits)
//   Configuration macro:
//     TIMER_LOAD_LOCK_EN : when defined, loadn is ignored while enable=1
//                          so digits cannot be entered during cooking.
//   Priority per edge: clearn > loadn > enable > hold.
// ----------------------------------------------------------------------------
module microwave_timer
  import microwave_timer_pkg::*;
#(
  parameter logic [3:0] SEC_TENS_MAX = microwave_timer_pkg::SEC_TENS_MAX,
  parameter logic [3:0] DIGIT_MAX    = microwave_timer_pkg::DIGIT_MAX
) (
  input  logic                clock,
  input  logic                clearn,
  microwave_timer_if.slave    tmr_if
);

  cmd_e cmd;
  logic load_req;
  logic zero_w;

  bcd_t ones_q;
  bcd_t tens_q;
  bcd_t mins_q;

  logic load_en;
  logic count_en;
  logic borrow_ones;
  logic borrow_tens;
  logic borrow_mins;

  assign zero_w = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == 4'd0);

  // Command decode. An out-of-range keypad digit still claims the edge
  // (load has priority) but changes nothing.
  always_comb begin
    load_req = !tmr_if.loadn;
`ifdef TIMER_LOAD_LOCK_EN
    load_req = load_req && !tmr_if.enable;
`else
    load_req = load_req;
`endif
    cmd = CMD_HOLD;
    if (!clearn) begin
      cmd = CMD_CLEAR;
    end else if (load_req) begin
      cmd = is_valid_digit(tmr_if.data) ? CMD_LOAD : CMD_HOLD;
    end else if (tmr_if.enable && !zero_w) begin
      // Gating on zero keeps 0:00 from wrapping to 9:59.
      cmd = CMD_COUNT;
    end
  end

  assign load_en  = (cmd == CMD_LOAD);
  assign count_en = (cmd == CMD_COUNT);

  // Load shifts digits left: data -> ones -> tens -> mins; old mins is lost.
  // Decrement ripples via borrow: ones -> tens -> mins.
  microwave_timer_bcd_down_digit #(
    .WRAP_MAX (DIGIT_MAX)
  ) u_ones (
    .clk        (clock),
    .rst_n      (clearn),
    .load_i     (load_en),
    .load_val_i (tmr_if.data),
    .dec_i      (count_en),
    .q_o        (ones_q),
    .borrow_o   (borrow_ones)
  );

  microwave_timer_bcd_down_digit #(
    .WRAP_MAX (SEC_TENS_MAX)
  ) u_tens (
    .clk        (clock),
    .rst_n      (clearn),
    .load_i     (load_en),
    .load_val_i (ones_q),
    .dec_i      (borrow_ones),
    .q_o        (tens_q),
    .borrow_o   (borrow_tens)
  );

  // The minutes borrow can only fire at 0:00, which count gating excludes.
  microwave_timer_bcd_down_digit #(
    .WRAP_MAX (DIGIT_MAX)
  ) u_mins (
    .clk        (clock),
    .rst_n      (clearn),
    .load_i     (load_en),
    .load_val_i (tens_q),
    .dec_i      (borrow_tens),
    .q_o        (mins_q),
    .borrow_o   (borrow_mins)
  );

  logic unused_borrow;
  assign unused_borrow = borrow_mins;

  assign tmr_if.sec_ones = ones_q;
  assign tmr_if.sec_tens = tens_q;
  assign tmr_if.mins     = mins_q;
  assign tmr_if.zero     = zero_w;

endmodule

// File: tb/tb_microwave_timer.sv
// ----------------------------------------------------------------------------
// tb_microwave_timer
//   Directed scenarios for the cook timer: async clear, load, invalid digit,
//   countdown to 0:00, multi-digit borrow, pause, out-of-range tens digit,
//   load while counting (TIMER_LOAD_LOCK_EN aware) and hold at zero.
// ----------------------------------------------------------------------------
module tb_microwave_timer;
  import microwave_timer_pkg::*;

  logic clock;
  logic clearn;
  int   checks;
  int   failures;

  microwave_timer_if tb_if ();

  microwave_timer dut (
    .clock  (clock),
    .clearn (clearn),
    .tmr_if (tb_if.slave)
  );

  logic [11:0] got_d;
  assign got_d = {tb_if.mins, tb_if.sec_tens, tb_if.sec_ones};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load_digit(input bcd_t d);
    tb_if.loadn = 1'b0;
    tb_if.data  = d;
    tick(1);
    tb_if.loadn = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (got_d !== 12'h000 || tb_if.zero !== 1'b1) begin
      $display("FAIL reset_initial got=%h z=%b exp=000 z=1", got_d, tb_if.zero);
      failures++;
    end
    clearn = 1'b1;
    tick(1);
    load_digit(4'd5);
    tb_if.enable = 1'b1;
    tick(1);
    checks++;
    if (got_d !== 12'h004 || tb_if.zero !== 1'b0) begin
      $display("FAIL reset_precount got=%h z=%b exp=004 z=0", got_d, tb_if.zero);
      failures++;
    end
    #2;
    clearn = 1'b0;
    #1;
    checks++;
    if (got_d !== 12'h000 || tb_if.zero !== 1'b1) begin
      $display("FAIL reset_async got=%h z=%b exp=000 z=1", got_d, tb_if.zero);
      failures++;
    end
    tb_if.loadn = 1'b0;
    tb_if.data  = 4'd6;
    tick(3);
    checks++;
    if (got_d !== 12'h000 || tb_if.zero !== 1'b1) begin
      $display("FAIL reset_held got=%h z=%b exp=000 z=1", got_d, tb_if.zero);
      failures++;
    end
    tb_if.loadn  = 1'b1;
    tb_if.enable = 1'b0;
    clearn       = 1'b1;
    tick(1);
    checks++;
    if (got_d !== 12'h000) begin
      $display("FAIL reset_release got=%h exp=000", got_d);
      failures++;
    end
    $display("test_reset: value=%h zero=%b", got_d, tb_if.zero);
  endtask

  task automatic test_load();
    load_digit(4'd7);
    checks++;
    if (got_d !== 12'h007 || tb_if.zero !== 1'b0) begin
      $display("FAIL load_7 got=%h z=%b exp=007 z=0", got_d, tb_if.zero);
      failures++;
    end
    tick(9);
    checks++;
    if (got_d !== 12'h007) begin
      $display("FAIL load_hold got=%h exp=007", got_d);
      failures++;
    end
    $display("test_load: value=%h", got_d);
  endtask

  task automatic test_invalid();
    load_digit(4'd12);
    checks++;
    if (got_d !== 12'h007) begin
      $display("FAIL invalid_12 got=%h exp=007", got_d);
      failures++;
    end
    load_digit(4'd15);
    checks++;
    if (got_d !== 12'h007) begin
      $display("FAIL invalid_15 got=%h exp=007", got_d);
      failures++;
    end
    $display("test_invalid: value=%h", got_d);
  endtask

  task automatic test_countdown();
    logic [11:0] exp_d;
    logic        exp_z;
    tb_if.enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      exp_d = (i < 7) ? 12'(7 - i) : 12'h000;
      exp_z = (i >= 7);
      checks++;
      if (got_d !== exp_d || tb_if.zero !== exp_z) begin
        $display("FAIL countdown_step%0d got=%h z=%b exp=%h z=%b", i, got_d, tb_if.zero, exp_d, exp_z);
        failures++;
      end
    end
    tb_if.enable = 1'b0;
    $display("test_countdown: value=%h zero=%b", got_d, tb_if.zero);
  endtask

  task automatic test_back_to_back_borrow();
    tb_if.loadn = 1'b0;
    tb_if.data  = 4'd1;
    tick(1);
    checks++;
    if (got_d !== 12'h001) begin
      $display("FAIL b2b_load1 got=%h exp=001", got_d);
      failures++;
    end
    tb_if.data = 4'd3;
    tick(1);
    checks++;
    if (got_d !== 12'h013) begin
      $display("FAIL b2b_load3 got=%h exp=013", got_d);
      failures++;
    end
    tb_if.data = 4'd0;
    tick(1);
    tb_if.loadn = 1'b1;
    checks++;
    if (got_d !== 12'h130) begin
      $display("FAIL b2b_load0 got=%h exp=130", got_d);
      failures++;
    end
    tb_if.enable = 1'b1;
    tick(1);
    checks++;
    if (got_d !== 12'h129) begin
      $display("FAIL borrow_1_29 got=%h exp=129", got_d);
      failures++;
    end
    tick(29);
    checks++;
    if (got_d !== 12'h100) begin
      $display("FAIL borrow_1_00 got=%h exp=100", got_d);
      failures++;
    end
    tick(1);
    checks++;
    if (got_d !== 12'h059) begin
      $display("FAIL borrow_0_59 got=%h exp=059", got_d);
      failures++;
    end
    tb_if.enable = 1'b0;
    tick(5);
    checks++;
    if (got_d !== 12'h059) begin
      $display("FAIL pause_hold got=%h exp=059", got_d);
      failures++;
    end
    tb_if.enable = 1'b1;
    tick(1);
    tb_if.enable = 1'b0;
    checks++;
    if (got_d !== 12'h058) begin
      $display("FAIL pause_resume got=%h exp=058", got_d);
      failures++;
    end
    $display("test_back_to_back_borrow: value=%h", got_d);
  endtask

  task automatic test_tens_overflow();
    load_digit(4'd7);
    checks++;
    if (got_d !== 12'h587) begin
      $display("FAIL ovf_load got=%h exp=587", got_d);
      failures++;
    end
    tb_if.enable = 1'b1;
    tick(7);
    checks++;
    if (got_d !== 12'h580) begin
      $display("FAIL ovf_580 got=%h exp=580", got_d);
      failures++;
    end
    tick(1);
    checks++;
    if (got_d !== 12'h579) begin
      $display("FAIL ovf_579 got=%h exp=579", got_d);
      failures++;
    end
    tick(10);
    tb_if.enable = 1'b0;
    checks++;
    if (got_d !== 12'h569) begin
      $display("FAIL ovf_569 got=%h exp=569", got_d);
      failures++;
    end
    load_digit(4'd2);
    checks++;
    if (got_d !== 12'h692) begin
      $display("FAIL mins_discard got=%h exp=692", got_d);
      failures++;
    end
    $display("test_tens_overflow: value=%h", got_d);
  endtask

  task automatic test_load_during_count();
    logic [11:0] exp_a;
    logic [11:0] exp_b;
`ifdef TIMER_LOAD_LOCK_EN
    exp_a = 12'h691;
    exp_b = 12'h690;
`else
    exp_a = 12'h923;
    exp_b = 12'h922;
`endif
    tb_if.enable = 1'b1;
    tb_if.loadn  = 1'b0;
    tb_if.data   = 4'd3;
    tick(1);
    tb_if.loadn = 1'b1;
    checks++;
    if (got_d !== exp_a) begin
      $display("FAIL load_while_count got=%h exp=%h", got_d, exp_a);
      failures++;
    end
    tick(1);
    tb_if.enable = 1'b0;
    checks++;
    if (got_d !== exp_b) begin
      $display("FAIL count_after_load got=%h exp=%h", got_d, exp_b);
      failures++;
    end
    $display("test_load_during_count: value=%h", got_d);
  endtask

  task automatic test_zero_hold();
    #2;
    clearn = 1'b0;
    #1;
    clearn = 1'b1;
    tick(1);
    load_digit(4'd1);
    checks++;
    if (got_d !== 12'h001 || tb_if.zero !== 1'b0) begin
      $display("FAIL zero_load1 got=%h z=%b exp=001 z=0", got_d, tb_if.zero);
      failures++;
    end
    tb_if.enable = 1'b1;
    tick(1);
    checks++;
    if (got_d !== 12'h000 || tb_if.zero !== 1'b1) begin
      $display("FAIL zero_reach got=%h z=%b exp=000 z=1", got_d, tb_if.zero);
      failures++;
    end
    tick(3);
    tb_if.enable = 1'b0;
    checks++;
    if (got_d !== 12'h000 || tb_if.zero !== 1'b1) begin
      $display("FAIL zero_nowrap got=%h z=%b exp=000 z=1", got_d, tb_if.zero);
      failures++;
    end
    $display("test_zero_hold: value=%h zero=%b", got_d, tb_if.zero);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    clearn       = 1'b0;
    tb_if.loadn  = 1'b1;
    tb_if.enable = 1'b0;
    tb_if.data   = 4'd0;
    tick(2);
    test_reset();
    test_load();
    test_invalid();
    test_countdown();
    test_back_to_back_borrow();
    test_tens_overflow();
    test_load_during_count();
    test_zero_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
